// File: rtl/rv_decode_pkg.sv
// Shared types for the decode queue: control bundle, FIFO entry, opcodes and the NOP word.
package rv_decode_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Entry PC is sized for the widest supported XLEN; narrower builds use the low bits.
  localparam int unsigned RV_MAX_PC_W = 62;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] res_src;
    logic       pc_sel;
    logic       jump;
    logic       branch;
    logic       alu_op1_sel;
    logic       alu_op2_sel;
    logic [2:0] funct3;
    logic [4:0] alu_ctrl;
  } rv_dec_ctrl_t;

  typedef struct packed {
    logic [31:0]            instr;
    logic [RV_MAX_PC_W-1:0] pc;
  } rv_entry_t;

  typedef enum logic [6:0] {
    OpLoad   = 7'h03,
    OpImm    = 7'h13,
    OpAuipc  = 7'h17,
    OpStore  = 7'h23,
    OpReg    = 7'h33,
    OpLui    = 7'h37,
    OpBranch = 7'h63,
    OpJalr   = 7'h67,
    OpJal    = 7'h6F
  } rv_opcode_e;

endpackage

// File: rtl/core_decode.sv
// Combinational RV32I decoder: register indices, immediate and control fields.
module core_decode
  import rv_decode_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [31:0] o_imm,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [1:0]  o_res_src,
  output logic        o_pc_sel,
  output logic        o_jump,
  output logic        o_branch,
  output logic        o_alu_op1_sel,
  output logic        o_alu_op2_sel,
  output logic [2:0]  o_funct3,
  output logic [4:0]  o_alu_ctrl,
  output logic        o_inv_instr
);
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  funct3;

  assign funct3   = i_instr[14:12];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];
  assign o_rd     = i_instr[11:7];
  assign o_funct3 = funct3;

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21],
                  1'b0};

  // alu_ctrl = {compare, alternate (sub/sra), funct3}
  always_comb begin
    o_imm         = 32'b0;
    o_reg_write   = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_res_src     = 2'b00;
    o_pc_sel      = 1'b0;
    o_jump        = 1'b0;
    o_branch      = 1'b0;
    o_alu_op1_sel = 1'b0;
    o_alu_op2_sel = 1'b0;
    o_alu_ctrl    = 5'b0;
    o_inv_instr   = 1'b0;
    case (i_instr[6:0])
      OpImm: begin
        o_imm         = imm_i;
        o_reg_write   = 1'b1;
        o_alu_op2_sel = 1'b1;
        o_alu_ctrl    = {1'b0, (funct3 == 3'b101) & i_instr[30], funct3};
      end
      OpReg: begin
        o_reg_write = 1'b1;
        o_alu_ctrl  = {1'b0, i_instr[30], funct3};
      end
      OpLoad: begin
        o_imm         = imm_i;
        o_reg_write   = 1'b1;
        o_mem_read    = 1'b1;
        o_res_src     = 2'b01;
        o_alu_op2_sel = 1'b1;
      end
      OpStore: begin
        o_imm         = imm_s;
        o_mem_write   = 1'b1;
        o_alu_op2_sel = 1'b1;
      end
      OpBranch: begin
        o_imm      = imm_b;
        o_branch   = 1'b1;
        o_alu_ctrl = {2'b10, funct3};
      end
      OpJal: begin
        o_imm       = imm_j;
        o_reg_write = 1'b1;
        o_jump      = 1'b1;
        o_res_src   = 2'b10;
      end
      OpJalr: begin
        o_imm         = imm_i;
        o_reg_write   = 1'b1;
        o_jump        = 1'b1;
        o_pc_sel      = 1'b1;
        o_res_src     = 2'b10;
        o_alu_op2_sel = 1'b1;
      end
      OpLui: begin
        o_imm       = imm_u;
        o_reg_write = 1'b1;
        o_res_src   = 2'b11;
      end
      OpAuipc: begin
        o_imm         = imm_u;
        o_reg_write   = 1'b1;
        o_alu_op1_sel = 1'b1;
        o_alu_op2_sel = 1'b1;
      end
      default: o_inv_instr = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_decode_queue.sv
// Fetch-to-execute decode queue: DEPTH-entry FIFO, head decode, registered output stage.
// Optional DECODE_QUEUE_BYPASS_EN decodes straight from fetch when the queue is empty.
module rv_decode_queue
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_fetch_valid,
  output logic                       o_fetch_ready,
  input  logic [31:0]                i_fetch_data,
  input  logic [XLEN-3:0]            i_fetch_pc,
  output logic                       o_dec_valid,
  input  logic                       i_dec_ready,
  output logic [XLEN-3:0]            o_pc,
  output logic [XLEN-3:0]            o_pc_p4,
  output logic [4:0]                 o_rs1,
  output logic [4:0]                 o_rs2,
  output logic [4:0]                 o_rd,
  output logic [31:0]                o_imm,
  output rv_dec_ctrl_t               o_ctrl,
  output logic                       o_inv_instr,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);
  localparam int unsigned PcW    = XLEN - 2;
  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);

  rv_entry_t         mem_q [DEPTH];
  rv_entry_t         head;
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              push, pop, bypass, wr_en, out_free, load;
  logic              unused_head_pc;

  logic [31:0]       dec_instr, dec_imm;
  logic [PcW-1:0]    dec_pc;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd;
  rv_dec_ctrl_t      dec_ctrl;
  logic              dec_inv;

  logic              valid_q, valid_d, inv_q, inv_d;
  logic [PcW-1:0]    pc_q, pc_d, pc_p4_q, pc_p4_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [31:0]       imm_q, imm_d;
  rv_dec_ctrl_t      ctrl_q, ctrl_d;

  // Ready looks only at registered occupancy so a same-cycle pop never frees a full queue.
  assign o_fetch_ready = (level_q != LevelW'(DEPTH)) & ~i_flush;
  assign push          = i_fetch_valid & o_fetch_ready;
  assign out_free      = ~valid_q | i_dec_ready;
  assign pop           = out_free & (level_q != '0);

`ifdef DECODE_QUEUE_BYPASS_EN
  assign bypass = push & (level_q == '0) & out_free;
`else
  assign bypass = 1'b0;
`endif

  assign wr_en = push & ~bypass;
  assign load  = pop | bypass;

  assign head           = mem_q[rd_ptr_q];
  assign unused_head_pc = ^head.pc;
  assign dec_instr      = bypass ? i_fetch_data : ((level_q != '0) ? head.instr : RV_NOP);
  assign dec_pc         = bypass ? i_fetch_pc : head.pc[PcW-1:0];

  core_decode u_core_decode (
    .i_instr      (dec_instr),
    .o_rs1        (dec_rs1),
    .o_rs2        (dec_rs2),
    .o_rd         (dec_rd),
    .o_imm        (dec_imm),
    .o_reg_write  (dec_ctrl.reg_write),
    .o_mem_read   (dec_ctrl.mem_read),
    .o_mem_write  (dec_ctrl.mem_write),
    .o_res_src    (dec_ctrl.res_src),
    .o_pc_sel     (dec_ctrl.pc_sel),
    .o_jump       (dec_ctrl.jump),
    .o_branch     (dec_ctrl.branch),
    .o_alu_op1_sel(dec_ctrl.alu_op1_sel),
    .o_alu_op2_sel(dec_ctrl.alu_op2_sel),
    .o_funct3     (dec_ctrl.funct3),
    .o_alu_ctrl   (dec_ctrl.alu_ctrl),
    .o_inv_instr  (dec_inv)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    pc_p4_d  = pc_p4_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    ctrl_d   = ctrl_q;
    inv_d    = inv_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
      pc_d     = '0;
      pc_p4_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AddrW'(1);
      level_d = level_q + LevelW'(wr_en) - LevelW'(pop);
      if (load) begin
        valid_d = 1'b1;
        pc_d    = dec_pc;
        pc_p4_d = dec_pc + PcW'(1);
        rs1_d   = dec_rs1;
        rs2_d   = dec_rs2;
        rd_d    = dec_rd;
        imm_d   = dec_imm;
        ctrl_d  = dec_ctrl;
        inv_d   = dec_inv;
      end else if (out_free) begin
        valid_d = 1'b0;
      end
    end
  end

  // Storage is not reset; cleared pointers and level make stale entries unreachable.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{instr: i_fetch_data, pc: RV_MAX_PC_W'(i_fetch_pc)};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      pc_p4_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      ctrl_q   <= '0;
      inv_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      pc_p4_q  <= pc_p4_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      ctrl_q   <= ctrl_d;
      inv_q    <= inv_d;
    end
  end

  assign o_dec_valid = valid_q;
  assign o_pc        = pc_q;
  assign o_pc_p4     = pc_p4_q;
  assign o_rs1       = rs1_q;
  assign o_rs2       = rs2_q;
  assign o_rd        = rd_q;
  assign o_imm       = imm_q;
  assign o_ctrl      = ctrl_q;
  assign o_inv_instr = inv_q;
  assign o_level     = level_q;

endmodule
